postadder_fp2: RTL and testbench

POSTADDER_FP2 -- requirements
Module: postadder_fp2

---
 rtl/postadder_fp2.sv | 141 ++++++++++++++
 tb/tb_postadder_fp2.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/postadder_fp2.sv
// Post-adder for a two-lane (Fp2) multiplier pipeline.
// Collects product beats into groups and combines them into the real and
// imaginary coefficients z0/z1:
//   mode 10 (Karatsuba)        : T0, T1, T2 -> z0 = T0 - T1, z1 = T2 - T0 - T1
//   mode 01 (complex squaring) : T0, T1     -> z0 = T0,      z1 = 2*T1
//   mode 00/11 (pass-through)  : D          -> z0 = D,       z1 = 0
// All lanes are unreduced redundant values that wrap modulo 2^W.
// Optional feature: define POSTADDER_ABORT_EN to add an 'abort' input that
// discards a partially received group.
module postadder_fp2 #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rstn,
`ifdef POSTADDER_ABORT_EN
  input  logic         abort,
`endif
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_z0,
  output logic [W-1:0] out_z1,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StGot1, StGot2} state_e;

  localparam logic [1:0] ModeKara = 2'b10;
  localparam logic [1:0] ModeSqr  = 2'b01;

  state_e         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [W-1:0]   acc0_q, acc0_d;
  logic [W-1:0]   acc1_q, acc1_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_z0_q, out_z0_d;
  logic [W-1:0]   out_z1_q, out_z1_d;
  logic           accept;

  // Ready depends only on the output register, never on the beat position,
  // so a held result stalls every beat of a group alike.
  assign in_ready  = !(out_valid_q && !out_ready);
`ifdef POSTADDER_ABORT_EN
  assign accept    = in_valid && in_ready && !abort;
`else
  assign accept    = in_valid && in_ready;
`endif
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign out_z0    = out_z0_q;
  assign out_z1    = out_z1_q;

  // Next-state: group sequencing, running accumulators and result register.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    acc0_d      = acc0_q;
    acc1_d      = acc1_q;
    out_valid_d = out_valid_q;
    out_z0_d    = out_z0_q;
    out_z1_d    = out_z1_q;

    // Drain of the held result; overridden below if a final beat lands too.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        StIdle: begin
          mode_d = mode;
          if (mode == ModeKara || mode == ModeSqr) begin
            acc0_d  = in_data;
            acc1_d  = -in_data;
            state_d = StGot1;
          end else begin
            out_valid_d = 1'b1;
            out_z0_d    = in_data;
            out_z1_d    = '0;
          end
        end
        StGot1: begin
          if (mode_q == ModeKara) begin
            acc0_d  = acc0_q - in_data;
            acc1_d  = acc1_q - in_data;
            state_d = StGot2;
          end else begin
            // Squaring: second beat is a0*a1, doubled by a shift.
            out_valid_d = 1'b1;
            out_z0_d    = acc0_q;
            out_z1_d    = {in_data[W-2:0], 1'b0};
            state_d     = StIdle;
          end
        end
        StGot2: begin
          out_valid_d = 1'b1;
          out_z0_d    = acc0_q;
          out_z1_d    = acc1_q + in_data;
          state_d     = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end

`ifdef POSTADDER_ABORT_EN
    // Abort drops the partial group; a held output is left alone.
    if (abort) begin
      state_d = StIdle;
      acc0_d  = '0;
      acc1_d  = '0;
    end
`endif
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      mode_q      <= 2'b00;
      acc0_q      <= '0;
      acc1_q      <= '0;
      out_valid_q <= 1'b0;
      out_z0_q    <= '0;
      out_z1_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      acc0_q      <= acc0_d;
      acc1_q      <= acc1_d;
      out_valid_q <= out_valid_d;
      out_z0_q    <= out_z0_d;
      out_z1_q    <= out_z1_d;
    end
  end

endmodule

// File: tb/tb_postadder_fp2.sv
// Self-checking bench for postadder_fp2 at W=16 with a group-level reference.
module tb_postadder_fp2;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_z0;
  logic [W-1:0] out_z1;
  logic         busy;
`ifdef POSTADDER_ABORT_EN
  logic         abort;
`endif

  int checks = 0;
  int errors = 0;

  postadder_fp2 #(.W(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
`ifdef POSTADDER_ABORT_EN
    .abort     (abort),
`endif
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z0    (out_z0),
    .out_z1    (out_z1),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: result of a whole group from its beats.
  function automatic logic [2*W-1:0] ref_group(input logic [1:0] m, input logic [W-1:0] t0,
                                               input logic [W-1:0] t1, input logic [W-1:0] t2);
    logic [W-1:0] z0, z1;
    if (m == 2'b10) begin
      z0 = t0 - t1;
      z1 = t2 - t0 - t1;
    end else if (m == 2'b01) begin
      z0 = t0;
      z1 = t1 * 2;
    end else begin
      z0 = t0;
      z1 = 0;
    end
    return {z0, z1};
  endfunction

  function automatic int nbeats(input logic [1:0] m);
    if (m == 2'b10) return 3;
    if (m == 2'b01) return 2;
    return 1;
  endfunction

  // Present one beat, wait (bounded) for ready, return #1 after the accepting edge.
  task automatic drive_beat(input logic [1:0] m, input logic [W-1:0] d);
    int n = 0;
    mode     = m;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL beat_ready_timeout: in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // One full group, busy checked after each beat, result checked after the last.
  task automatic run_group(input string name, input logic [1:0] m, input logic [1:0] later_m,
                           input logic [W-1:0] t0, input logic [W-1:0] t1,
                           input logic [W-1:0] t2);
    logic [W-1:0] beats [3];
    logic [2*W-1:0] exp;
    int nb;
    beats[0] = t0; beats[1] = t1; beats[2] = t2;
    nb  = nbeats(m);
    exp = ref_group(m, t0, t1, t2);
    for (int i = 0; i < nb; i++) begin
      drive_beat((i == 0) ? m : later_m, beats[i]);
      checks++;
      if (busy !== (i != nb - 1)) begin
        errors++;
        $display("FAIL %s busy beat%0d: got=%b required=%b", name, i, busy, (i != nb - 1));
      end
    end
    checks++;
    if (out_valid !== 1'b1 || out_z0 !== exp[2*W-1:W] || out_z1 !== exp[W-1:0]) begin
      errors++;
      $display("FAIL %s result: valid=%b z0=%h z1=%h required valid=1 z0=%h z1=%h",
               name, out_valid, out_z0, out_z1, exp[2*W-1:W], exp[W-1:0]);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mode = 2'b00; in_data = '0;
`ifdef POSTADDER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_z0 !== 16'h0 ||
        out_z1 !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b z0=%h z1=%h required 0 0 1 0000 0000",
               out_valid, busy, in_ready, out_z0, out_z1);
    end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_group("karatsuba_vec", 2'b10, 2'b10, 16'h0006, 16'h0002, 16'h0014);
    checks++;
    if (out_z0 !== 16'h0004 || out_z1 !== 16'h000C) begin
      errors++;
      $display("FAIL karatsuba_const: z0=%h z1=%h required 0004 000c", out_z0, out_z1);
    end
    run_group("square_wrap", 2'b01, 2'b01, 16'hFFFD, 16'h8001, 16'h0000);
    checks++;
    if (out_z0 !== 16'hFFFD || out_z1 !== 16'h0002) begin
      errors++;
      $display("FAIL square_const: z0=%h z1=%h required fffd 0002", out_z0, out_z1);
    end
    // No new final beat: valid clears one cycle after the handshake, data holds.
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_z0 !== 16'hFFFD || out_z1 !== 16'h0002) begin
      errors++;
      $display("FAIL drain_hold: valid=%b z0=%h z1=%h required 0 fffd 0002",
               out_valid, out_z0, out_z1);
    end
  endtask

  task automatic test_random();
    for (int g = 0; g < 40; g++) begin
      run_group("random", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                16'($urandom), 16'($urandom), 16'($urandom));
    end
  endtask

  task automatic test_backpressure();
    drive_beat(2'b00, 16'h1234);
    out_ready = 1'b0;
    mode = 2'b00; in_data = 16'h5678; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_z0 !== 16'h1234 || out_z1 !== 16'h0) begin
      errors++;
      $display("FAIL bp_stall: valid=%b ready=%b z0=%h z1=%h required 1 0 1234 0000",
               out_valid, in_ready, out_z0, out_z1);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_release: in_ready=%b required=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_z0 !== 16'h5678 || out_z1 !== 16'h0) begin
      errors++;
      $display("FAIL bp_no_bubble: valid=%b z0=%h z1=%h required 1 5678 0000",
               out_valid, out_z0, out_z1);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || out_z0 !== 16'h5678) begin
      errors++;
      $display("FAIL bp_clear: valid=%b z0=%h required 0 5678", out_valid, out_z0);
    end
  endtask

  task automatic test_mode_change();
    // T1/T2 presented with mode 01: must be ignored, Karatsuba result expected.
    run_group("mode_change", 2'b10, 2'b01, 16'h0100, 16'h0030, 16'h0777);
  endtask

  task automatic test_reset_mid();
    drive_beat(2'b10, 16'h1111);
    drive_beat(2'b10, 16'h2222);
    rstn = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b valid=%b required 0 0", busy, out_valid);
    end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    run_group("after_reset", 2'b10, 2'b10, 16'h0009, 16'h0004, 16'h0030);
  endtask

`ifdef POSTADDER_ABORT_EN
  task automatic test_abort();
    @(posedge clk); #1;
    drive_beat(2'b10, 16'h4444);
    abort = 1'b1; mode = 2'b10; in_data = 16'h5555; in_valid = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort: busy=%b valid=%b required 0 0", busy, out_valid);
    end
    run_group("after_abort", 2'b10, 2'b10, 16'h0020, 16'h0005, 16'h0100);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_mode_change();
    test_reset_mid();
`ifdef POSTADDER_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
